adc_capture_hls_deadlock_report_unit: RTL and testbench

- System-level companion to the per-process deadlock detect units in the adc_capture HLS dataflow region.
- Collects every unit's dl_detect_out and arbitrates one origin process.
- Drives the broadcast dl_detect_in, the per-process origin pulse and token_clear.
- Confirms a cycle by waiting for the origin's token to return, then latches a sticky report (flag + process index) for the debug/status register.

---
 rtl/adc_capture_hls_dl_pkg.sv | 21 ++
 rtl/adc_capture_hls_dl_prio_enc.sv | 27 ++
 rtl/adc_capture_hls_deadlock_report_unit.sv | 150 +++++++++++++++
 tb/tb_adc_capture_hls_deadlock_report_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_hls_dl_pkg.sv
// Shared types and constants for the adc_capture HLS deadlock report logic.
package adc_capture_hls_dl_pkg;

    // Report FSM states:
    // ST_IDLE    | waiting for any unit to raise dl_detect_out
    // ST_ARM     | origin pulse issued, unit outputs still settling
    // ST_TRACE   | waiting for the token to come back to the origin
    // ST_BACKOFF | dl_detect_in dropped so units release their tokens
    // ST_DONE    | deadlock confirmed, report frozen until reset
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_TRACE   = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_DONE    = 3'd4
    } dl_state_e;

    localparam int DEFAULT_TIMEOUT = 1024;
    localparam int RETRY_CNT_W     = 8;

endpackage

// File: rtl/adc_capture_hls_dl_prio_enc.sv
// Lowest-index-wins priority encoder; gives index, one-hot and valid.
module adc_capture_hls_dl_prio_enc #(
    parameter int PROC_NUM   = 4,
    parameter int PROC_IDX_W = 2
) (
    input  logic [PROC_NUM-1:0]   req,
    output logic [PROC_IDX_W-1:0] idx,
    output logic [PROC_NUM-1:0]   onehot,
    output logic                  valid
);

    // Scan from the top so the lowest set bit is the last one to write.
    always_comb begin
        idx    = '0;
        onehot = '0;
        valid  = 1'b0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx    = PROC_IDX_W'(i);
                onehot = '0;
                onehot[i] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_capture_hls_deadlock_report_unit.sv
// System-level deadlock arbiter/reporter for the adc_capture dataflow region.
// Optional macro ADC_CAPTURE_DL_RETRY_CNT_EN adds a saturating retry_cnt output.
module adc_capture_hls_deadlock_report_unit
    import adc_capture_hls_dl_pkg::*;
#(
    parameter int PROC_NUM   = 4,
    parameter int PROC_IDX_W = 2,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int CNT_W      = 11
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PROC_NUM-1:0]    dl_detect_vec,
    output logic                   dl_detect_in,
    output logic [PROC_NUM-1:0]    origin,
    output logic                   token_clear,
    output logic                   deadlock_found,
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
    output logic [RETRY_CNT_W-1:0] retry_cnt,
`endif
    output logic [PROC_IDX_W-1:0]  deadlock_proc
);

    dl_state_e               state_q, state_d;
    logic                    dl_in_q, dl_in_d;
    logic [PROC_NUM-1:0]     origin_q, origin_d;
    logic                    tc_q, tc_d;
    logic                    found_q, found_d;
    logic [PROC_IDX_W-1:0]   proc_q, proc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PROC_IDX_W-1:0]   win_q, win_d;
    logic [PROC_NUM-1:0]     win_oh_q, win_oh_d;
    logic [PROC_IDX_W-1:0]   enc_idx;
    logic [PROC_NUM-1:0]     enc_oh;
    logic                    enc_valid;
    logic                    win_hit;
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
    logic [RETRY_CNT_W-1:0]  retry_q, retry_d;
`endif

    adc_capture_hls_dl_prio_enc #(
        .PROC_NUM   (PROC_NUM),
        .PROC_IDX_W (PROC_IDX_W)
    ) u_prio_enc (
        .req    (dl_detect_vec),
        .idx    (enc_idx),
        .onehot (enc_oh),
        .valid  (enc_valid)
    );

    // Winner is tracked as a one-hot mask to avoid a variable bit select.
    assign win_hit = |(dl_detect_vec & win_oh_q);

    // State and output registers; every output is driven straight from here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            dl_in_q  <= 1'b0;
            origin_q <= '0;
            tc_q     <= 1'b0;
            found_q  <= 1'b0;
            proc_q   <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            win_oh_q <= '0;
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
            retry_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            dl_in_q  <= dl_in_d;
            origin_q <= origin_d;
            tc_q     <= tc_d;
            found_q  <= found_d;
            proc_q   <= proc_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            win_oh_q <= win_oh_d;
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
            retry_q  <= retry_d;
`endif
        end
    end

    // Next-state and next-output logic; pulses default to zero each cycle.
    always_comb begin
        state_d  = state_q;
        dl_in_d  = dl_in_q;
        origin_d = '0;
        tc_d     = 1'b0;
        found_d  = found_q;
        proc_d   = proc_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        win_oh_d = win_oh_q;
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
        retry_d  = retry_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    win_d    = enc_idx;
                    win_oh_d = enc_oh;
                    dl_in_d  = 1'b1;
                    origin_d = enc_oh;
                    cnt_d    = '0;
                    state_d  = ST_ARM;
                end
            end
            // Units still reflect the origin cycle combinationally; ignore them.
            ST_ARM: state_d = ST_TRACE;
            ST_TRACE: begin
                cnt_d = cnt_q + 1'b1;
                // Token return beats timeout when both land on the same cycle.
                if (win_hit) begin
                    tc_d    = 1'b1;
                    found_d = 1'b1;
                    proc_d  = win_q;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    dl_in_d = 1'b0;
                    state_d = ST_BACKOFF;
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
`endif
                end
            end
            ST_BACKOFF: begin
                dl_in_d = 1'b0;
                state_d = ST_IDLE;
            end
            // dl_detect_in stays high to freeze unit state for debug readout.
            ST_DONE: state_d = ST_DONE;
            default: begin
                dl_in_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dl_detect_in   = dl_in_q;
    assign origin         = origin_q;
    assign token_clear    = tc_q;
    assign deadlock_found = found_q;
    assign deadlock_proc  = proc_q;
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
    assign retry_cnt      = retry_q;
`endif

endmodule

// File: tb/tb_adc_capture_hls_deadlock_report_unit.sv
// Directed bench for adc_capture_hls_deadlock_report_unit (4, 8 and 1 process
// instances). Honors ADC_CAPTURE_DL_RETRY_CNT_EN for the retry_cnt checks.
module tb_adc_capture_hls_deadlock_report_unit;

    localparam int TO = 1024;

    logic       clock;
    logic       reset;
    logic [3:0] vec;
    logic [7:0] vec8;
    logic [0:0] vec1;

    logic       dl_in, tc, found;
    logic [3:0] origin;
    logic [1:0] proc;
    logic       dl_in8, tc8, found8;
    logic [7:0] origin8;
    logic [2:0] proc8;
    logic       dl_in1, tc1, found1;
    logic [0:0] origin1;
    logic [0:0] proc1;
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
    logic [7:0] retry, retry8, retry1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    adc_capture_hls_deadlock_report_unit #(
        .PROC_NUM(4), .PROC_IDX_W(2), .TIMEOUT(TO), .CNT_W(11)
    ) dut (
        .clock(clock), .reset(reset), .dl_detect_vec(vec),
        .dl_detect_in(dl_in), .origin(origin), .token_clear(tc),
        .deadlock_found(found),
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
        .retry_cnt(retry),
`endif
        .deadlock_proc(proc)
    );

    adc_capture_hls_deadlock_report_unit #(
        .PROC_NUM(8), .PROC_IDX_W(3), .TIMEOUT(TO), .CNT_W(11)
    ) dut8 (
        .clock(clock), .reset(reset), .dl_detect_vec(vec8),
        .dl_detect_in(dl_in8), .origin(origin8), .token_clear(tc8),
        .deadlock_found(found8),
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
        .retry_cnt(retry8),
`endif
        .deadlock_proc(proc8)
    );

    adc_capture_hls_deadlock_report_unit #(
        .PROC_NUM(1), .PROC_IDX_W(1), .TIMEOUT(TO), .CNT_W(11)
    ) dut1 (
        .clock(clock), .reset(reset), .dl_detect_vec(vec1),
        .dl_detect_in(dl_in1), .origin(origin1), .token_clear(tc1),
        .deadlock_found(found1),
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
        .retry_cnt(retry1),
`endif
        .deadlock_proc(proc1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    // Expected 4-process outputs: {dl_in, origin, tc, found, proc}.
    task automatic chk4(input string tag, input logic d, input logic [3:0] o,
                        input logic t, input logic f, input logic [1:0] p);
        chk({tag, ".dl_in"}, 32'(dl_in), 32'(d));
        chk({tag, ".origin"}, 32'(origin), 32'(o));
        chk({tag, ".token_clear"}, 32'(tc), 32'(t));
        chk({tag, ".found"}, 32'(found), 32'(f));
        chk({tag, ".proc"}, 32'(proc), 32'(p));
    endtask

    task automatic chk_all_zero(input string tag);
        chk4(tag, 1'b0, 4'h0, 1'b0, 1'b0, 2'd0);
        chk({tag, ".u8"}, 32'({dl_in8, origin8, tc8, found8, proc8}), 32'h0);
        chk({tag, ".u1"}, 32'({dl_in1, origin1, tc1, found1, proc1}), 32'h0);
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
        chk({tag, ".retry"}, 32'(retry), 32'h0);
`endif
    endtask

    // Asserts reset between clock edges, checks, then releases at a negedge.
    task automatic mid_cycle_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero(tag);
        vec = '0; vec8 = '0; vec1 = '0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        vec = '0; vec8 = '0; vec1 = '0;
        #3;
        chk_all_zero("por");
        step(2);
        reset = 1'b1;
        step(2);
        chk_all_zero("idle");

        // Self-loop on process 2 plus 8-proc (bit 7) and 1-proc instances.
        vec = 4'b0100; vec8 = 8'h80; vec1 = 1'b1;
        step(1);
        chk4("t1_arm", 1'b1, 4'b0100, 1'b0, 1'b0, 2'd0);
        chk("t1_u8_origin", 32'(origin8), 32'h80);
        chk("t1_u1_origin", 32'(origin1), 32'h1);
        step(1);
        chk4("t1_trace", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        chk("t1_u8_origin0", 32'(origin8), 32'h0);
        step(1);
        chk4("t1_found", 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2);
        chk("t1_u8_report", 32'({tc8, found8, proc8}), {27'd0, 1'b1, 1'b1, 3'd7});
        chk("t1_u1_report", 32'({tc1, found1, proc1}), {29'd0, 1'b1, 1'b1, 1'b0});
        vec = 4'b0001;
        step(1);
        chk4("t1_done", 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2);
        step(3);
        chk4("t1_held", 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2);
        chk("t1_u8_held", 32'({dl_in8, tc8, found8, proc8}), {26'd0, 1'b1, 1'b0, 1'b1, 3'd7});
        mid_cycle_reset("rst_done");

        // Simultaneous detect on 1 and 3: lowest index wins, bit 3 ignored.
        vec = 4'b1010;
        step(1);
        chk4("t2_arm", 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0);
        vec = 4'b1000;
        step(4);
        chk4("t2_bit3_ignored", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        vec = 4'b0010;
        step(1);
        chk4("t2_found", 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1);
        mid_cycle_reset("rst_t2");

        // Timeout with a non-winner bit active, then a boundary race.
        vec = 4'b0001;
        step(1);
        chk4("t3_arm", 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0);
        vec = 4'b0010;
        step(1);
        step(TO - 1);
        chk4("t3_last_trace", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        step(1);
        chk4("t3_backoff", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
        chk("t3_retry", 32'(retry), 32'd1);
`endif
        vec = 4'b0001;
        step(1);
        chk4("t3_idle", 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
        step(1);
        chk4("t3_rearm", 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0);
        vec = 4'b0000;
        step(1);
        step(TO - 1);
        chk4("t4_pre_race", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        vec = 4'b0001;
        step(1);
        chk4("t4_race_found", 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0);
        step(1);
        chk4("t4_no_backoff", 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0);
`ifdef ADC_CAPTURE_DL_RETRY_CNT_EN
        chk("t4_retry_held", 32'(retry), 32'd1);
`endif
        mid_cycle_reset("rst_t4");

        // Async reset while in TRACE, then quiet IDLE afterwards.
        vec = 4'b0100;
        step(1);
        vec = 4'b0000;
        step(6);
        chk4("t5_in_trace", 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
        mid_cycle_reset("t5_reset_trace");
        step(3);
        chk_all_zero("t5_stay_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
